// File: rtl/cic3_decim_row.sv
// cic3_decim_row
//   A row of NUM_CH third-order CIC decimators fed by 1-bit sigma-delta
//   bitstreams. All channels share one clock and one decimation counter.
//   The counter's strobe acts as a clock enable for the comb stages, so no
//   divided clock is needed. The decimation ratio R = decim_m1 + 1 can be
//   changed at runtime. A change triggers a one-cycle clear of the filter
//   state.
//
//   Optional feature macro: CIC3_ROW_SETTLE_EN
//     When defined, out_valid is suppressed for the first 3 strobes after
//     reset or a ratio-change clear, while the comb pipeline fills.
//
// Ports
//   clk        filter clock (same rate as the modulator clock)
//   reset      synchronous, active-high reset
//   en         processing enable; all state holds while low
//   decim_m1   R-1, legal range 1..MAX_DECIM-1 (0 is clamped to R=2)
//   in         modulator bits, channel k on in[k]
//   out        unsigned decimated words, channel k on out[k*OUT_W +: OUT_W]
//   out_valid  one-cycle pulse marking a new word on every channel

module cic3_decim_row #(
  parameter int NUM_CH    = 24,
  parameter int MAX_DECIM = 256,
  parameter int OUT_W     = 3 * $clog2(MAX_DECIM) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [$clog2(MAX_DECIM)-1:0]  decim_m1,
  input  logic [NUM_CH-1:0]             in,
  output logic [NUM_CH*OUT_W-1:0]       out,
  output logic                          out_valid
);

  localparam int DW = $clog2(MAX_DECIM);

  logic [DW-1:0] decim_clamped;
  logic [DW-1:0] decim_q;
  logic [DW-1:0] r_act;
  logic [DW-1:0] cnt;
  logic          clear;
  logic          strobe;
  logic          settled;

  // R=1 is not a legal ratio. It is turned into R=2 before it can reach
  // r_act, so a request for 0 or for 1 behaves identically.
  assign decim_clamped = (decim_m1 == '0) ? DW'(1) : decim_m1;

  // A ratio change is detected one cycle after the new value is captured.
  // That cycle becomes the clear cycle.
  assign clear  = (decim_q != r_act);
  assign strobe = en & ~clear & (cnt == r_act);

`ifdef CIC3_ROW_SETTLE_EN
  logic [1:0] settle_cnt;

  assign settled = (settle_cnt == 2'd3);

  // This counter saturates at 3. The first three strobes after a restart
  // still update out, but they carry comb outputs that are not yet
  // meaningful, so they are not flagged.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      settle_cnt <= 2'd0;
    end else if (strobe && !settled) begin
      settle_cnt <= settle_cnt + 2'd1;
    end
  end
`else
  assign settled = 1'b1;
`endif

  // Shared control: the ratio capture, the active ratio, the decimation
  // counter and the registered valid pulse. During reset, r_act loads
  // directly from the port, so coming out of reset does not cause a
  // spurious clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      decim_q   <= decim_clamped;
      r_act     <= decim_clamped;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      decim_q <= decim_clamped;
      if (clear) begin
        r_act     <= decim_q;
        cnt       <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= strobe & settled;
        if (en) begin
          cnt <= strobe ? '0 : cnt + DW'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [OUT_W-1:0] in_q;
    logic [OUT_W-1:0] i1;
    logic [OUT_W-1:0] i2;
    logic [OUT_W-1:0] i3;
    logic [OUT_W-1:0] d1;
    logic [OUT_W-1:0] d2;
    logic [OUT_W-1:0] d3;
    logic [OUT_W-1:0] out_r;
    logic [OUT_W-1:0] c1;
    logic [OUT_W-1:0] c2;
    logic [OUT_W-1:0] c3;

    // The comb chain is combinational off i3. Its results are only
    // committed on a strobe. Modulo-2^OUT_W wrap in the integrators
    // cancels out exactly in the combs.
    assign c1 = i3 - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    // Integrators run every enabled cycle. Combs and out advance only on a
    // strobe. A clear resets the filter but keeps the last word on out.
    always_ff @(posedge clk) begin
      if (reset) begin
        in_q  <= '0;
        i1    <= '0;
        i2    <= '0;
        i3    <= '0;
        d1    <= '0;
        d2    <= '0;
        d3    <= '0;
        out_r <= '0;
      end else if (clear) begin
        in_q <= '0;
        i1   <= '0;
        i2   <= '0;
        i3   <= '0;
        d1   <= '0;
        d2   <= '0;
        d3   <= '0;
      end else if (en) begin
        in_q <= {{(OUT_W-1){1'b0}}, in[k]};
        i1   <= i1 + in_q;
        i2   <= i2 + i1;
        i3   <= i3 + i2;
        if (strobe) begin
          d1    <= i3;
          d2    <= c1;
          d3    <= c2;
          out_r <= c3;
        end
      end
    end

    assign out[k*OUT_W +: OUT_W] = out_r;
  end

endmodule

// File: tb/tb_cic3_decim_row.sv
// Directed testbench for cic3_decim_row with the default parameters
// (24 channels, MAX_DECIM 256, 25-bit words). Inputs are driven and outputs
// are sampled on the falling clock edge.

module tb_cic3_decim_row;

  localparam int NUM_CH    = 24;
  localparam int MAX_DECIM = 256;
  localparam int DW        = 8;
  localparam int OUT_W     = 25;
  localparam int VW        = NUM_CH * OUT_W;
  localparam int LIMIT     = 3000;
`ifdef CIC3_ROW_SETTLE_EN
  localparam int SETTLE = 3;
`else
  localparam int SETTLE = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [DW-1:0]     decim_m1;
  logic [NUM_CH-1:0] in;
  logic [VW-1:0]     out;
  logic              out_valid;

  int passed = 0;
  int total  = 0;

  cic3_decim_row #(
    .NUM_CH   (NUM_CH),
    .MAX_DECIM(MAX_DECIM),
    .OUT_W    (OUT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .decim_m1 (decim_m1),
    .in       (in),
    .out      (out),
    .out_valid(out_valid)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Hard time limit in case the design never produces out_valid
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and return at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive every input in one go
  task automatic applyStimulus(input logic r, input logic e,
                               input logic [DW-1:0] d, input logic [NUM_CH-1:0] b);
    reset    = r;
    en       = e;
    decim_m1 = d;
    in       = b;
  endtask

  // Single comparison point; counts checks and passes
  task automatic checkOutput(input string tag, input logic [VW-1:0] obs,
                             input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Count clocks until out_valid is seen, bounded by limit
  task automatic waitValid(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < limit);
  endtask

  task automatic skipValids(input int k);
    int n;
    repeat (k) waitValid(LIMIT, n);
  endtask

  function automatic logic [VW-1:0] rep(input logic [OUT_W-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i*OUT_W +: OUT_W] = v;
    return r;
  endfunction

  initial begin
    int n;
    int sum;
    int nz;
    logic other;
    logic bad;
    logic [OUT_W-1:0] word;
    logic [VW-1:0] ch5_mask;
    logic [NUM_CH-1:0] all1;

    all1     = '1;
    ch5_mask = '0;
    ch5_mask[5*OUT_W +: OUT_W] = '1;

    // Reset state
    applyStimulus(1'b1, 1'b0, 8'd3, '0);
    tick();
    tick();
    checkOutput("reset_out", out, '0);
    checkOutput("reset_valid", VW'(out_valid), '0);

    // R=4, DC all ones
    applyStimulus(1'b0, 1'b1, 8'd3, all1);
    waitValid(LIMIT, n);
    checkOutput("first_valid_r4", VW'(n), VW'(4 * (1 + SETTLE)));
    waitValid(LIMIT, n);
    checkOutput("period_r4", VW'(n), VW'(4));
    skipValids(14);
    checkOutput("dc_r4", out, rep(25'd64));

    // R=4, DC all zeros
    applyStimulus(1'b0, 1'b1, 8'd3, '0);
    skipValids(6);
    checkOutput("zero_r4", out, '0);

    // Single-cycle impulse on channel 5
    applyStimulus(1'b0, 1'b1, 8'd3, 24'h000020);
    tick();
    applyStimulus(1'b0, 1'b1, 8'd3, '0);
    sum   = 0;
    nz    = 0;
    other = 1'b0;
    for (int w = 0; w < 6; w++) begin
      waitValid(LIMIT, n);
      word = out[5*OUT_W +: OUT_W];
      sum += int'(word);
      if (word != '0) nz++;
      if ((out & ~ch5_mask) != '0) other = 1'b1;
    end
    checkOutput("impulse_sum", VW'(sum), VW'(16));
    checkOutput("impulse_nonzero_le4", VW'(nz <= 4), VW'(1));
    checkOutput("impulse_other_ch", VW'(other), '0);

    // Back to DC ones at R=4
    applyStimulus(1'b0, 1'b1, 8'd3, all1);
    skipValids(16);
    checkOutput("dc_r4_again", out, rep(25'd64));

    // Ratio change 4 -> 8 right after a valid word
    applyStimulus(1'b0, 1'b1, 8'd7, all1);
    tick();
    checkOutput("chg_no_valid_capture", VW'(out_valid), '0);
    tick();
    checkOutput("chg_no_valid_clear", VW'(out_valid), '0);
    checkOutput("chg_out_held", out, rep(25'd64));
    waitValid(LIMIT, n);
    checkOutput("chg_first_valid_r8", VW'(n), VW'(8 * (1 + SETTLE)));
    waitValid(LIMIT, n);
    checkOutput("period_r8", VW'(n), VW'(8));
    skipValids(10);
    checkOutput("dc_r8", out, rep(25'd512));

    // en low for 5 cycles, two cycles into a window
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 8'd7, all1);
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid) bad = 1'b1;
    end
    checkOutput("en_low_no_valid", VW'(bad), '0);
    applyStimulus(1'b0, 1'b1, 8'd7, all1);
    waitValid(LIMIT, n);
    checkOutput("en_low_spacing", VW'(2 + 5 + n), VW'(13));
    checkOutput("en_low_dc_held", out, rep(25'd512));

    // One-cycle reset between strobes, en kept high
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 8'd7, all1);
    tick();
    applyStimulus(1'b0, 1'b1, 8'd7, all1);
    checkOutput("rst_mid_out", out, '0);
    checkOutput("rst_mid_valid", VW'(out_valid), '0);
    waitValid(LIMIT, n);
    checkOutput("rst_mid_first_valid", VW'(n), VW'(8 * (1 + SETTLE)));
    skipValids(10);
    checkOutput("rst_mid_dc_r8", out, rep(25'd512));

    // decim_m1 = 0 clamps to R=2
    applyStimulus(1'b0, 1'b1, 8'd0, all1);
    tick();
    tick();
    waitValid(LIMIT, n);
    checkOutput("clamp_first_valid", VW'(n), VW'(2 * (1 + SETTLE)));
    waitValid(LIMIT, n);
    checkOutput("clamp_period_r2", VW'(n), VW'(2));
    skipValids(10);
    checkOutput("clamp_dc_r2", out, rep(25'd8));

    // R=256: full-scale DC, then zeros
    applyStimulus(1'b0, 1'b1, 8'd255, all1);
    tick();
    tick();
    waitValid(LIMIT, n);
    checkOutput("first_valid_r256", VW'(n), VW'(256 * (1 + SETTLE)));
    waitValid(LIMIT, n);
    checkOutput("period_r256", VW'(n), VW'(256));
    skipValids(7);
    checkOutput("dc_r256", out, rep(25'h1000000));
    applyStimulus(1'b0, 1'b1, 8'd255, '0);
    skipValids(5);
    checkOutput("zero_r256", out, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cic3_decim_row.md
# cic3_decim_row

Parametrised successor to the fixed 2x12 CIC3 filter row. NUM_CH third-order CIC decimators take 1-bit sigma-delta modulator bitstreams and run in a single clock domain. A shared decimation counter issues a comb-stage clock-enable strobe, so there is no divided clock. The decimation ratio is runtime-programmable up to MAX_DECIM, and an output-valid pulse tags each decimated word. The block sits between the modulator array and the output buffers/readout.

## Interface
- NUM_CH, 24: number of filter channels.
- MAX_DECIM, 256: largest decimation ratio R, a power of 2.
- OUT_W, 3*$clog2(MAX_DECIM)+1 (25 by default): derived; per-channel output and accumulator width.
- clk  input  1: filter clock, same frequency as the modulator clock.
- reset  input  1: synchronous, active-high reset.
- en  input  1: processing enable.
- decim_m1  input  $clog2(MAX_DECIM): R-1; R ranges 2..MAX_DECIM.
- in  input  NUM_CH: modulator bits, one per channel; channel k is in[k].
- out  output  NUM_CH*OUT_W: decimated words, unsigned; channel k occupies out[k*OUT_W +: OUT_W].
- out_valid  output  1: one-cycle pulse marking new data on all channels.

## Operation
- Per channel datapath:
  - in_q register, then integrators i1, i2, i3, then comb delays d1, d2, d3, then the out register.
  - All registers are OUT_W wide. Arithmetic is modulo 2^OUT_W (wrap is intended; the CIC result is exact).
- Every clk with en=1, all channels in parallel:
  - in_q <= in
  - i1 <= i1 + in_q
  - i2 <= i2 + i1
  - i3 <= i3 + i2
- Decimation counter cnt, shared by all channels:
  - Counts 0..R-1 while en=1 and wraps to 0.
  - strobe = en & (cnt == R-1).
- On a strobe cycle, per channel:
  - c1 = i3 - d1
  - c2 = c1 - d2
  - c3 = c2 - d3
  - d1 <= i3
  - d2 <= c1
  - d3 <= c2
  - out <= c3
- out_valid is a registered copy of strobe, qualified by the settle logic (see Configuration). out holds its value between strobes.
- en=0: every register holds, no strobe is issued, and out_valid=0.
- Ratio change:
  - decim_m1 is registered into r_act.
  - If the registered value differs from r_act, the next cycle performs a clear: in_q, integrators, combs, cnt and settle_cnt go to 0, and r_act is updated.
  - out is not cleared.
  - During the clear cycle, strobe and out_valid are forced to 0.
- decim_m1 = 0 (R=1) is illegal. The block clamps it to R=2.
- Steady DC input of all ones gives out = R^3; all zeros gives 0. For R=MAX_DECIM, R^3 = 2^(OUT_W-1), which fits in OUT_W bits.

## Timing
- Reset is synchronous. After reset, all datapath registers, cnt, settle_cnt, out and out_valid are 0, and r_act = decim_m1 as sampled in the reset cycle.
- The first strobe comes R cycles after the first en=1 cycle following reset. out_valid goes high one cycle after that strobe, in the same cycle the new out is visible.
- The out_valid period is exactly R cycles while en=1. It stretches by the number of en=0 cycles.
- Input-to-output group delay: in is registered once, then passes the integrator pipeline, so an input bit first affects out at the second strobe at the earliest.
- reset asserted mid-operation:
  - It wins over en and over a ratio-change clear.
  - out_valid is 0 in the cycle after reset is sampled.
  - No partial word is emitted.
- A ratio change coincident with a strobe cancels that strobe. No output is emitted for the old ratio.

## Configuration
- CIC3_ROW_SETTLE_EN defined:
  - A 2-bit settle_cnt suppresses out_valid for the first 3 strobes after reset or a ratio-change clear, while the comb pipeline fills.
  - out still updates on those strobes.
- Undefined: out_valid follows every strobe from the first one, and settle_cnt is not built.

## Test plan
- Reset, en=1, decim_m1=3, all in=1 for 64 cycles: out_valid every 4 cycles; every channel settles to 64. With SETTLE_EN, the first out_valid comes at the 4th strobe and reads 64 where the pipeline has filled.
- decim_m1=255, all in=1 for 2048 cycles: each channel settles to 16777216 (2^24) with no wrap error. All-zero input gives 0.
- Single-cycle impulse on in[5], R=4: the outputs of channel 5 sum to exactly 16. At most 4 consecutive words are nonzero. All other channels stay 0.
- Change decim_m1 from 3 to 7 mid-stream: one clear cycle, no out_valid in it, cnt restarts, then out_valid every 8 cycles and DC all-ones settles to 512.
- en toggled low for 5 cycles mid-window: no strobe while low, state is held, the out_valid spacing for that window is R+5, and the DC value is unchanged.
- Assert reset for 1 cycle between strobes: out and out_valid are 0 on the next cycle, and the first new out_valid comes R cycles after reset deasserts with en=1.
